// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage of the
// multicycle RV32I core.
package fetch_pkg;

  localparam int XLEN = 32;

  // Word presented to the decoder while no instruction is held (addi x0,x0,0)
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_WAIT,
    S_HOLD
  } fetchState_t;

  // Force an address onto a word boundary
  function automatic logic [XLEN-1:0] alignWord(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle of the fetch stage: instruction memory request/response,
// the valid/ready instruction stream to decode, and the redirect port.
// The master side is the fetch unit, the slave side is its environment.
interface fetch_unit_if;
  import fetch_pkg::*;

  logic            O_IMEM_REQ;
  logic [XLEN-1:0] O_IMEM_ADDR;
  logic            I_IMEM_GNT;
  logic            I_IMEM_RVALID;
  logic [XLEN-1:0] I_IMEM_RDATA;

  logic            O_VALID;
  logic [XLEN-1:0] O_INST;
  logic [XLEN-1:0] O_PC;
  logic            I_READY;

  logic            I_REDIRECT;
  logic [XLEN-1:0] I_REDIRECT_PC;
  logic            O_MISALIGN;

  modport master (
    output O_IMEM_REQ, O_IMEM_ADDR, O_VALID, O_INST, O_PC, O_MISALIGN,
    input  I_IMEM_GNT, I_IMEM_RVALID, I_IMEM_RDATA, I_READY,
           I_REDIRECT, I_REDIRECT_PC
  );

  modport slave (
    input  O_IMEM_REQ, O_IMEM_ADDR, O_VALID, O_INST, O_PC, O_MISALIGN,
    output I_IMEM_GNT, I_IMEM_RVALID, I_IMEM_RDATA, I_READY,
           I_REDIRECT, I_REDIRECT_PC
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one instruction
// memory read in flight, buffers the returned word for decode and handles
// branch/jump redirects. A redirect that lands while a read is in flight
// marks that read as killed so its late response is thrown away.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic         CLK,
  input  logic         RSTn,
  fetch_unit_if.master bus
);

  fetchState_t     state;
  logic [XLEN-1:0] pc;
  logic            kill;
  logic [XLEN-1:0] instBuf;
  logic [XLEN-1:0] pcBuf;
  logic            validReg;
  logic            misalignReg;

  logic [XLEN-1:0] pcInc;
  logic [XLEN-1:0] redirTarget;

  assign pcInc       = pc + XLEN'(4);
  assign redirTarget = alignWord(bus.I_REDIRECT_PC);

  // Fetch FSM with registered decode-side outputs; redirect overrides the pc last
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      kill        <= 1'b0;
      validReg    <= 1'b0;
      instBuf     <= NOP_INST;
      pcBuf       <= RESET_PC;
      misalignReg <= 1'b0;
    end else begin
      misalignReg <= 1'b0;
      case (state)
        S_BOOT: begin
          state <= S_FETCH;
        end
        S_FETCH: begin
          if (bus.I_IMEM_GNT) begin
            state <= S_WAIT;
            if (bus.I_REDIRECT) begin
              kill <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (bus.I_IMEM_RVALID) begin
            kill <= 1'b0;
            if (kill || bus.I_REDIRECT) begin
              state <= S_FETCH;
            end else begin
              validReg <= 1'b1;
              instBuf  <= bus.I_IMEM_RDATA;
              pcBuf    <= pc;
              pc       <= pcInc;
              state    <= S_HOLD;
            end
          end else if (bus.I_REDIRECT) begin
            kill <= 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.I_READY || bus.I_REDIRECT) begin
            validReg <= 1'b0;
            instBuf  <= NOP_INST;
            state    <= S_FETCH;
          end
        end
        default: begin
          state <= S_BOOT;
        end
      endcase
      if (bus.I_REDIRECT && (state != S_BOOT)) begin
        pc          <= redirTarget;
        misalignReg <= bus.I_REDIRECT_PC[1];
      end
    end
  end

  assign bus.O_IMEM_REQ  = (state == S_FETCH);
  assign bus.O_IMEM_ADDR = pc;
  assign bus.O_VALID     = validReg;
  assign bus.O_INST      = instBuf;
  assign bus.O_PC        = pcBuf;
  assign bus.O_MISALIGN  = misalignReg;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations, then randomized memory/decode/redirect traffic checked
// every cycle against a transaction-level model of the fetch stage.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;

  int checkCount = 0;
  int passCount  = 0;
  bit cmpOn      = 1'b0;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  // Free-running clock, 10 time units per cycle
  initial forever #5 CLK = ~CLK;

  // Model state: boot cycle, read in flight, instruction held, redirect epoch
  bit          mBoot       = 1'b1;
  bit          mOut        = 1'b0;
  bit          mHold       = 1'b0;
  bit          mMis        = 1'b0;
  logic [31:0] mFetch      = RESET_PC;
  logic [31:0] mGrantAddr  = 32'h0;
  logic [31:0] mHoldPc     = RESET_PC;
  logic [31:0] mHoldInst   = NOP_INST;
  int unsigned mEpoch      = 0;
  int unsigned mGrantEpoch = 0;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic applyStimulus(input bit rst, input bit gnt, input bit rvalid,
                               input logic [31:0] rdata, input bit ready,
                               input bit redir, input logic [31:0] redirPc);
    RSTn              = rst;
    bus.I_IMEM_GNT    = gnt;
    bus.I_IMEM_RVALID = rvalid;
    bus.I_IMEM_RDATA  = rdata;
    bus.I_READY       = ready;
    bus.I_REDIRECT    = redir;
    bus.I_REDIRECT_PC = redirPc;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "Req"},   32'(bus.O_IMEM_REQ), 32'd0);
    checkOutput({tag, "Addr"},  bus.O_IMEM_ADDR, RESET_PC);
    checkOutput({tag, "Valid"}, 32'(bus.O_VALID), 32'd0);
    checkOutput({tag, "Inst"},  bus.O_INST, 32'h0000_0013);
    checkOutput({tag, "Pc"},    bus.O_PC, RESET_PC);
    checkOutput({tag, "Mis"},   32'(bus.O_MISALIGN), 32'd0);
  endtask

  // Transaction-level model: reads, kills by redirect epoch, held instruction
  initial begin : modelProc
    bit doRedir;
    bit reqNow;
    bit preOut;
    bit preHold;
    forever begin
      @(posedge CLK);
      if (!RSTn) begin
        mBoot  = 1'b1;
        mOut   = 1'b0;
        mHold  = 1'b0;
        mMis   = 1'b0;
        mFetch = RESET_PC;
        mEpoch = 0;
      end else begin
        preOut  = mOut;
        preHold = mHold;
        reqNow  = !mBoot && !mHold && !mOut;
        doRedir = bus.I_REDIRECT && !mBoot;
        mMis    = doRedir && bus.I_REDIRECT_PC[1];
        if (preHold && (bus.I_READY || doRedir)) mHold = 1'b0;
        if (preOut && bus.I_IMEM_RVALID) begin
          mOut = 1'b0;
          if (!doRedir && (mEpoch == mGrantEpoch)) begin
            mHold     = 1'b1;
            mHoldPc   = mGrantAddr;
            mHoldInst = bus.I_IMEM_RDATA;
            mFetch    = mGrantAddr + 32'd4;
          end
        end
        if (reqNow && bus.I_IMEM_GNT) begin
          mOut        = 1'b1;
          mGrantAddr  = mFetch;
          mGrantEpoch = mEpoch;
        end
        if (doRedir) begin
          mEpoch++;
          mFetch = {bus.I_REDIRECT_PC[31:2], 2'b00};
        end
        mBoot = 1'b0;
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model
  initial begin : compareProc
    bit expReq;
    forever begin
      @(negedge CLK);
      if (cmpOn) begin
        expReq = !mBoot && !mHold && !mOut;
        checkOutput("req", 32'(bus.O_IMEM_REQ), 32'(expReq));
        if (expReq) checkOutput("addr", bus.O_IMEM_ADDR, mFetch);
        checkOutput("addrAlign", 32'(bus.O_IMEM_ADDR[1:0]), 32'd0);
        checkOutput("valid", 32'(bus.O_VALID), 32'(mHold));
        checkOutput("inst", bus.O_INST, mHold ? mHoldInst : NOP_INST);
        if (mHold) checkOutput("pc", bus.O_PC, mHoldPc);
        checkOutput("misalign", 32'(bus.O_MISALIGN), 32'(mMis));
      end
    end
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    bus.I_IMEM_GNT    = 1'b0;
    bus.I_IMEM_RVALID = 1'b0;
    bus.I_IMEM_RDATA  = 32'h0;
    bus.I_READY       = 1'b0;
    bus.I_REDIRECT    = 1'b0;
    bus.I_REDIRECT_PC = 32'h0;
    RSTn = 1'b0;
    @(negedge CLK);
    cmpOn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0042);
    checkReset("rst");

    // Boot, first fetch from address 0 with zero-wait memory
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("bootReq", 32'(bus.O_IMEM_REQ), 32'd1);
    checkOutput("bootAddr", bus.O_IMEM_ADDR, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("waitReq", 32'(bus.O_IMEM_REQ), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0);
    checkOutput("firstValid", 32'(bus.O_VALID), 32'd1);
    checkOutput("firstInst", bus.O_INST, 32'h0050_0093);
    checkOutput("firstPc", bus.O_PC, 32'h0);

    // Decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      idle();
      checkOutput("stallInst", bus.O_INST, 32'h0050_0093);
      checkOutput("stallPc", bus.O_PC, 32'h0);
      checkOutput("stallReq", 32'(bus.O_IMEM_REQ), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("relValid", 32'(bus.O_VALID), 32'd0);
    checkOutput("relInst", bus.O_INST, 32'h0000_0013);
    checkOutput("relReq", 32'(bus.O_IMEM_REQ), 32'd1);
    checkOutput("relAddr", bus.O_IMEM_ADDR, 32'h4);

    // Redirect while waiting: late response must be dropped
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0100);
    checkOutput("killMis", 32'(bus.O_MISALIGN), 32'd0);
    checkOutput("killReq", 32'(bus.O_IMEM_REQ), 32'd0);
    idle();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    checkOutput("dropValid", 32'(bus.O_VALID), 32'd0);
    checkOutput("dropInst", bus.O_INST, 32'h0000_0013);
    checkOutput("dropReq", 32'(bus.O_IMEM_REQ), 32'd1);
    checkOutput("dropAddr", bus.O_IMEM_ADDR, 32'h0000_0100);

    // Misaligned redirect target
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0202);
    checkOutput("misPulse", 32'(bus.O_MISALIGN), 32'd1);
    checkOutput("misAddr", bus.O_IMEM_ADDR, 32'h0000_0200);
    checkOutput("misValid", 32'(bus.O_VALID), 32'd0);
    idle();
    checkOutput("misEnd", 32'(bus.O_MISALIGN), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h00A0_0113, 1'b0, 1'b0, 32'h0);
    checkOutput("misFetchPc", bus.O_PC, 32'h0000_0200);

    // Redirect together with ready in hold squashes the instruction
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0300);
    checkOutput("sqValid", 32'(bus.O_VALID), 32'd0);
    checkOutput("sqInst", bus.O_INST, 32'h0000_0013);
    checkOutput("sqAddr", bus.O_IMEM_ADDR, 32'h0000_0300);

    // PC wraps from the top of the address space
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    checkOutput("topAddr", bus.O_IMEM_ADDR, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0073, 1'b0, 1'b0, 32'h0);
    checkOutput("topPc", bus.O_PC, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("wrapAddr", bus.O_IMEM_ADDR, 32'h0);

    // Reset while waiting, then a late response
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkReset("midRst");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    checkOutput("lateValid", 32'(bus.O_VALID), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    checkOutput("lateValid2", 32'(bus.O_VALID), 32'd0);
    checkOutput("lateReq", 32'(bus.O_IMEM_REQ), 32'd1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin : randCycle
      bit          rst;
      bit          gnt;
      bit          rv;
      bit          rdy;
      bit          re;
      logic [31:0] dat;
      logic [31:0] rpc;
      rst = ($urandom_range(0, 299) != 0);
      gnt = ($urandom_range(0, 2) != 0);
      if (mOut) begin
        rv  = ($urandom_range(0, 2) == 0);
        dat = memWord(mGrantAddr);
      end else begin
        rv  = ($urandom_range(0, 7) == 0);
        dat = $urandom;
      end
      rdy = ($urandom_range(0, 3) != 0);
      re  = ($urandom_range(0, 11) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = {28'hFFF_FFFF, rpc[3:0]};
      applyStimulus(rst, gnt, rv, dat, rdy, re, rpc);
    end

    #1;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
